// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick helper for sram_port_arbiter.
// Exposes arb_state_e (ARB, LOCKED) and rr_pick(valid, ptr, n) -> one-hot grant.
package sram_arb_pkg;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  localparam int MAX_REQ = 32;

  // First valid bit at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] g;
    logic               found;
    int unsigned        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[4:0]]) begin
        g[idx[4:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: one-hot grant of first valid at or after ptr.
// Ports: valid_i [N], ptr_i [log2 N], grant_o [N] one-hot.
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  assign grant_o = N'(rr_pick(MAX_REQ'(valid_i), 32'(ptr_i), N));

endmodule

// File: rtl/sram.sv
// Simple multi-port SRAM: combinational read, write at rising edge.
// Ports: clk, rst, wr_en/write_address/new_data per write port, read_address/data_out per read port.
module sram #(
  parameter int SIZE       = 1024,
  parameter int DATA_WIDTH = 8,
  parameter bit RESETABLE  = 1'b0,
  parameter int RD_PORTS   = 1,
  parameter int WR_PORTS   = 1,
  localparam int AW        = $clog2(SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [WR_PORTS-1:0]                  wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]          write_address,
  input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  new_data,
  input  logic [RD_PORTS-1:0][AW-1:0]          read_address,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  data_out
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];

  // Contents clear on reset only when RESETABLE is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (RESETABLE) begin
        for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p]) mem_q[write_address[p]] <= new_data[p];
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    assign data_out[p] = mem_q[read_address[p]];
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1R1W sram among REQUESTERS clients, with lock.
// Ports: req_* per client in, req_ready one-hot grant, rsp_valid/rsp_rdata read return.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int  REQUESTERS = 4,
  parameter int  SIZE       = 1024,
  parameter int  DATA_WIDTH = 8,
  parameter bit  RESETABLE  = 1'b0,
  localparam int AW         = $clog2(SIZE),
  localparam int PW         = $clog2(REQUESTERS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQUESTERS-1:0]                  req_valid,
  input  logic [REQUESTERS-1:0]                  req_we,
  input  logic [REQUESTERS-1:0]                  req_lock,
  input  logic [REQUESTERS-1:0][AW-1:0]          req_addr,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [REQUESTERS-1:0]                  req_ready,
  output logic [REQUESTERS-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]                  rsp_rdata
);

  arb_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [REQUESTERS-1:0] rr_grant, grant;
  logic [PW-1:0]         g_idx;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en, rd_en;

  rr_picker #(.N(REQUESTERS)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) g_idx = PW'(i);
    end
  end

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    return (v == PW'(REQUESTERS - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    grant   = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      ARB: begin
        grant = rr_grant;
        if (|rr_grant) begin
          if (req_lock[g_idx]) begin
            state_d = LOCKED;
            owner_d = g_idx;
          end else begin
            ptr_d = inc_mod(g_idx);
          end
        end
      end
      LOCKED: begin
        // Owner dropping valid releases the lock with no grant this cycle.
        if (req_valid[owner_q]) begin
          grant = REQUESTERS'(1) << owner_q;
          if (!req_lock[owner_q]) begin
            state_d = ARB;
            ptr_d   = inc_mod(owner_q);
          end
        end else begin
          state_d = ARB;
          ptr_d   = inc_mod(owner_q);
        end
      end
      default: ;
    endcase
  end

  assign req_ready = grant;
  assign sel_addr  = req_addr[g_idx];
  assign sel_wdata = req_wdata[g_idx];
  assign wr_en     = (|grant) && req_we[g_idx];
  assign rd_en     = (|grant) && !req_we[g_idx];

  sram #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .RESETABLE  (RESETABLE),
    .RD_PORTS   (1),
    .WR_PORTS   (1)
  ) u_sram (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .write_address (sel_addr),
    .new_data      (sel_wdata),
    .read_address  (sel_addr),
    .data_out      (rd_data)
  );

  always_comb begin
    rsp_valid_d = rd_en ? grant : '0;
    rsp_rdata_d = rd_en ? rd_data : rsp_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter (4 clients, 1024x8).
// Vectors hold inputs plus expected grant, next-cycle rsp_valid and rsp_rdata.
module tb_sram_port_arbiter;

  typedef struct {
    logic [3:0]       v;
    logic [3:0]       we;
    logic [3:0]       lk;
    logic [3:0][9:0]  addr;
    logic [3:0][7:0]  wd;
    logic [3:0]       rdy;
    logic [3:0]       rv;
    logic [7:0]       rd;
    bit               chk;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_we;
  logic [3:0]      req_lock;
  logic [3:0][9:0] req_addr;
  logic [3:0][7:0] req_wdata;
  logic [3:0]      req_ready;
  logic [3:0]      rsp_valid;
  logic [7:0]      rsp_rdata;

  int total;
  int passed;

  sram_port_arbiter #(
    .REQUESTERS (4),
    .SIZE       (1024),
    .DATA_WIDTH (8),
    .RESETABLE  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [3:0]  v, we, lk,
    input logic [39:0] addr,
    input logic [31:0] wd,
    input logic [3:0]  rdy, rv,
    input logic [7:0]  rd,
    input bit          chk
  );
    vec_t x;
    x.v = v; x.we = we; x.lk = lk;
    x.addr = addr; x.wd = wd;
    x.rdy = rdy; x.rv = rv; x.rd = rd; x.chk = chk;
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic apply(input vec_t x);
    req_valid = x.v;
    req_we    = x.we;
    req_lock  = x.lk;
    req_addr  = x.addr;
    req_wdata = x.wd;
  endtask

  // {c3,c2,c1,c0} addresses: even clients read 0 (0x11), odd read 5 (0xA5)
  localparam logic [39:0] ARD = {10'd5, 10'd0, 10'd5, 10'd0};

  vec_t tbl[23];
  vec_t vx;

  initial begin
    tbl[0]  = mk(4'b0001, 4'b0001, 4'b0000, {30'd0, 10'd5}, 32'h000000A5,
                 4'b0001, 4'b0000, 8'h00, 1'b0);
    tbl[1]  = mk(4'b0100, 4'b0000, 4'b0000, {10'd0, 10'd5, 20'd0}, 32'h0,
                 4'b0100, 4'b0100, 8'hA5, 1'b1);
    tbl[2]  = mk(4'b1000, 4'b1000, 4'b0000, 40'd0, 32'h11000000,
                 4'b1000, 4'b0000, 8'hA5, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tbl[3+k] = mk(4'b1111, 4'b0000, 4'b0000, ARD, 32'h0,
                    4'(1 << (k % 4)), 4'(1 << (k % 4)),
                    (k % 2 == 0) ? 8'h11 : 8'hA5, 1'b1);
    end
    tbl[11] = mk(4'b0010, 4'b0010, 4'b0000, {20'd0, 10'd3, 10'd0}, 32'h00003C00,
                 4'b0010, 4'b0000, 8'hA5, 1'b1);
    tbl[12] = mk(4'b0001, 4'b0000, 4'b0000, {30'd0, 10'd3}, 32'h0,
                 4'b0001, 4'b0001, 8'h3C, 1'b1);
    tbl[13] = mk(4'b0100, 4'b0000, 4'b0000, 40'd0, 32'h0,
                 4'b0100, 4'b0100, 8'h11, 1'b1);
    tbl[14] = mk(4'b1111, 4'b0000, 4'b1000, ARD, 32'h0,
                 4'b1000, 4'b1000, 8'hA5, 1'b1);
    tbl[15] = mk(4'b1111, 4'b1000, 4'b1000, {10'd7, 30'd0}, 32'h77000000,
                 4'b1000, 4'b0000, 8'hA5, 1'b1);
    tbl[16] = mk(4'b1111, 4'b1000, 4'b0000, {10'd8, 30'd0}, 32'h88000000,
                 4'b1000, 4'b0000, 8'hA5, 1'b1);
    tbl[17] = mk(4'b1111, 4'b0000, 4'b0000, {10'd7, 30'd0}, 32'h0,
                 4'b0001, 4'b0001, 8'h11, 1'b1);
    tbl[18] = mk(4'b1111, 4'b0000, 4'b0010, {20'd0, 10'd7, 10'd0}, 32'h0,
                 4'b0010, 4'b0010, 8'h77, 1'b1);
    tbl[19] = mk(4'b1101, 4'b0000, 4'b0010, {20'd0, 10'd7, 10'd0}, 32'h0,
                 4'b0000, 4'b0000, 8'h77, 1'b1);
    tbl[20] = mk(4'b1111, 4'b0000, 4'b0000, {10'd8, 30'd0}, 32'h0,
                 4'b0100, 4'b0100, 8'h11, 1'b1);
    tbl[21] = mk(4'b1111, 4'b0000, 4'b0000, {10'd8, 30'd0}, 32'h0,
                 4'b1000, 4'b1000, 8'h88, 1'b1);
    tbl[22] = mk(4'b1111, 4'b0000, 4'b0000, ARD, 32'h0,
                 4'b0001, 4'b0001, 8'h11, 1'b1);

    total = 0;
    passed = 0;
    rst = 1'b1;
    apply(mk(4'b0, 4'b0, 4'b0, 40'd0, 32'd0, 4'b0, 4'b0, 8'h0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 8'(rsp_valid), 8'h00);
    check("reset_rsp_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i]);
      #1;
      check($sformatf("v%0d_ready", i), 8'(req_ready), 8'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), 8'(rsp_valid), 8'(tbl[i].rv));
      if (tbl[i].chk)
        check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tbl[i].rd);
    end

    // Reset asserted during the acceptance cycle of a read by client 2.
    vx = mk(4'b0100, 4'b0000, 4'b0000, {10'd0, 10'd5, 20'd0}, 32'h0,
            4'b0100, 4'b0000, 8'h00, 1'b0);
    apply(vx);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_rsp_valid", 8'(rsp_valid), 8'h00);
    check("rst_async_rsp_rdata", rsp_rdata, 8'h00);
    @(posedge clk);
    #1;
    check("rst_edge_rsp_valid", 8'(rsp_valid), 8'h00);
    check("rst_edge_rsp_rdata", rsp_rdata, 8'h00);
    #2;
    rst = 1'b0;
    apply(mk(4'b1111, 4'b0000, 4'b0000, ARD, 32'h0,
             4'b0001, 4'b0001, 8'h11, 1'b1));
    #1;
    check("post_rst_ready", 8'(req_ready), 8'h01);
    @(posedge clk);
    #1;
    check("post_rst_rsp_valid", 8'(rsp_valid), 8'h01);
    check("post_rst_rsp_rdata", rsp_rdata, 8'h11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
